// File: rtl/rvl_ctrl_port_arb.sv
// ----------------------------------------------------------------------------
// rvl_ctrl_port_arb
//
// Round-robin arbiter sharing the user port of the Reveal control-register
// RAM between NUM_REQ (2..4) requesters. Each requester issues single-beat
// reads/writes through a valid/ready handshake. The grant is combinational,
// so an accepted beat reaches the RAM on the same edge. Read data comes back
// one cycle later, and rsp_vld tells the issuing requester that it is valid.
//
// Optional feature: define RVL_CTRL_ARB_LOCK_EN to compile in burst lock.
// A requester that holds req_lock keeps the port for up to MAX_LOCK
// consecutive beats. Without the macro, req_lock is ignored.
//
// Ports (all in the usr_clk domain):
//   usr_clk    rising-edge clock
//   usr_rst    synchronous, active-high reset
//   req_vld    per-requester transaction valid
//   req_we     per-requester write (1) / read (0)
//   req_lock   per-requester burst-lock request
//   req_addr   flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata  flattened write data, same packing
//   req_rdy    one-hot-or-zero grant (equals the accept vector)
//   rsp_vld    one-hot-or-zero read-data valid, one cycle after a read accept
//   rsp_rdata  read data shared by all requesters (mem_rdata passthrough)
//   mem_ce     RAM user-port enable
//   mem_we     RAM user-port write enable
//   mem_addr   RAM user-port address
//   mem_wdata  RAM user-port write data
//   mem_rdata  RAM user-port read data (1-cycle latency)
// ----------------------------------------------------------------------------
module rvl_ctrl_port_arb #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int MAX_LOCK   = 16
) (
  input  logic                          usr_clk,
  input  logic                          usr_rst,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic [NUM_REQ-1:0]            rsp_vld,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          mem_ce,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  logic [IDX_W-1:0]   last_gnt;
  logic               rr_any;
  logic [IDX_W-1:0]   rr_idx;
  logic               win_any;
  logic [IDX_W-1:0]   win_idx;
  logic               gnt_any;
  logic               win_we;
  logic [NUM_REQ-1:0] rsp_vld_p1;

  // Round-robin search starting one past the last accepted requester.
  always_comb begin
    int c;
    c      = 0;
    rr_any = 1'b0;
    rr_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = int'(last_gnt) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!rr_any && req_vld[IDX_W'(c)]) begin
        rr_any = 1'b1;
        rr_idx = IDX_W'(c);
      end
    end
  end

`ifdef RVL_CTRL_ARB_LOCK_EN
  typedef enum logic {LK_UNLOCKED, LK_LOCKED} lock_state_t;

  localparam int CNT_W = 9;

  lock_state_t      lock_st;
  logic [IDX_W-1:0] lock_owner;
  logic [CNT_W-1:0] lock_cnt;
  logic             owner_vld;
  logic             locked_hold;

  assign owner_vld   = req_vld[lock_owner];
  // The owner keeps the port only while it is still requesting. Otherwise
  // everyone arbitrates normally in the same cycle.
  assign locked_hold = (lock_st == LK_LOCKED) && owner_vld;
  assign win_any     = locked_hold ? 1'b1 : rr_any;
  assign win_idx     = locked_hold ? lock_owner : rr_idx;

  always_ff @(posedge usr_clk) begin
    if (usr_rst) begin
      lock_st    <= LK_UNLOCKED;
      lock_owner <= '0;
      lock_cnt   <= '0;
    end else if (gnt_any) begin
      if (locked_hold) begin
        // Beat from the owner: release on lock drop or on the MAX_LOCK-th beat.
        if (!req_lock[win_idx] ||
            (lock_cnt + CNT_W'(1)) == CNT_W'(MAX_LOCK)) begin
          lock_st  <= LK_UNLOCKED;
          lock_cnt <= '0;
        end else begin
          lock_cnt <= lock_cnt + CNT_W'(1);
        end
      end else if (req_lock[win_idx]) begin
        lock_st    <= LK_LOCKED;
        lock_owner <= win_idx;
        lock_cnt   <= CNT_W'(1);
      end else begin
        lock_st  <= LK_UNLOCKED;
        lock_cnt <= '0;
      end
    end else if (lock_st == LK_LOCKED && !owner_vld) begin
      lock_st  <= LK_UNLOCKED;
      lock_cnt <= '0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign win_any     = rr_any;
  assign win_idx     = rr_idx;
`endif

  // Stage p0: grant and RAM drive, all combinational and forced idle in reset.
  assign gnt_any = win_any & ~usr_rst;

  always_comb begin
    req_rdy   = '0;
    win_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_any && win_idx == IDX_W'(i)) begin
        req_rdy[i] = 1'b1;
        win_we     = req_we[i];
        mem_addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata  = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign mem_ce = gnt_any;
  assign mem_we = win_we;

  // Stage p1: read-return tag, aligned with the RAM's 1-cycle read latency.
  always_ff @(posedge usr_clk) begin
    if (usr_rst) begin
      last_gnt   <= IDX_W'(NUM_REQ - 1);
      rsp_vld_p1 <= '0;
    end else begin
      rsp_vld_p1 <= win_we ? '0 : req_rdy;
      if (gnt_any) last_gnt <= win_idx;
    end
  end

  assign rsp_vld   = rsp_vld_p1;
  assign rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_rvl_ctrl_port_arb.sv
module tb_rvl_ctrl_port_arb;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_vld, req_we, req_lock, req_rdy, rsp_vld;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
  logic            mem_ce, mem_we;
  logic [AW-1:0]   mem_addr;

  logic [DW-1:0]   ram [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rvl_ctrl_port_arb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_LOCK(4)
  ) dut (
    .usr_clk  (clk),
    .usr_rst  (rst),
    .req_vld  (req_vld),
    .req_we   (req_we),
    .req_lock (req_lock),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_rdy  (req_rdy),
    .rsp_vld  (rsp_vld),
    .rsp_rdata(rsp_rdata),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // RAM user port, unregistered-output mode: read data one cycle after ce.
  always_ff @(posedge clk) begin
    if (mem_ce && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_ce && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NR-1:0] fair_exp [6];
    logic [NR-1:0] lock_exp [5];
    logic [NR-1:0] prev;

    rst = 1'b1; req_vld = 2'b11; req_we = 2'b00; req_lock = 2'b00;
    req_addr = '0; req_wdata = '0;

    // Reset held three cycles with both requesters valid.
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      chk("rst_rdy", 64'(req_rdy), 64'(2'b00));
      chk("rst_ce", 64'(mem_ce), 64'd0);
      chk("rst_rsp", 64'(rsp_vld), 64'(2'b00));
    end
    chk("rst_addr", 64'(mem_addr), 64'd0);

    // Release: requester 0 wins immediately.
    rst = 1'b0; settle();
    chk("first_rdy", 64'(req_rdy), 64'(2'b01));
    chk("first_ce", 64'(mem_ce), 64'd1);
    cyc();

    // req1 writes DEADBEEF to 0x10; the read from reset release returns now.
    req_vld = 2'b10; req_we = 2'b10;
    req_addr[AW +: AW] = 8'h10; req_wdata[DW +: DW] = 32'hDEADBEEF;
    settle();
    chk("first_rsp", 64'(rsp_vld), 64'(2'b01));
    chk("wr_rdy", 64'(req_rdy), 64'(2'b10));
    chk("wr_we", 64'(mem_we), 64'd1);
    chk("wr_addr", 64'(mem_addr), 64'h10);
    chk("wr_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    cyc();

    // Single read by req0 of 0x10.
    req_vld = 2'b01; req_we = 2'b00; req_addr[0 +: AW] = 8'h10;
    settle();
    chk("wr_no_rsp", 64'(rsp_vld), 64'(2'b00));
    chk("rd_rdy", 64'(req_rdy), 64'(2'b01));
    chk("rd_ce", 64'(mem_ce), 64'd1);
    chk("rd_addr", 64'(mem_addr), 64'h10);
    cyc();
    req_vld = 2'b00; settle();
    chk("rd_rsp", 64'(rsp_vld), 64'(2'b01));
    chk("rd_data", 64'(rsp_rdata), 64'hDEADBEEF);
    chk("idle_ce", 64'(mem_ce), 64'd0);
    chk("idle_addr", 64'(mem_addr), 64'd0);
    chk("idle_we", 64'(mem_we), 64'd0);
    cyc();

    // Write then read: req1 writes 0x5A5A5A5A to 0x03, req0 reads it.
    req_vld = 2'b10; req_we = 2'b10;
    req_addr[AW +: AW] = 8'h03; req_wdata[DW +: DW] = 32'h5A5A5A5A;
    settle();
    chk("wr2_rdy", 64'(req_rdy), 64'(2'b10));
    cyc();
    req_vld = 2'b01; req_we = 2'b00; req_addr[0 +: AW] = 8'h03;
    settle();
    chk("wr2_no_rsp", 64'(rsp_vld), 64'(2'b00));
    chk("rd2_rdy", 64'(req_rdy), 64'(2'b01));
    cyc();
    req_vld = 2'b00; settle();
    chk("rd2_rsp", 64'(rsp_vld), 64'(2'b01));
    chk("rd2_data", 64'(rsp_rdata), 64'h5A5A5A5A);
    cyc();

    // req1 write alone so the pointer sits on requester 1.
    req_vld = 2'b10; req_we = 2'b10;
    req_addr[AW +: AW] = 8'h21; req_wdata[DW +: DW] = 32'h11111111;
    settle();
    chk("wr3_rdy", 64'(req_rdy), 64'(2'b10));
    cyc();

    // Fairness: both read for 6 cycles, req0 at 0x10, req1 at 0x03.
    fair_exp[0] = 2'b01; fair_exp[1] = 2'b10; fair_exp[2] = 2'b01;
    fair_exp[3] = 2'b10; fair_exp[4] = 2'b01; fair_exp[5] = 2'b10;
    req_vld = 2'b11; req_we = 2'b00;
    req_addr[0 +: AW] = 8'h10; req_addr[AW +: AW] = 8'h03;
    prev = 2'b00;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk($sformatf("fair_rdy%0d", i), 64'(req_rdy), 64'(fair_exp[i]));
      chk($sformatf("fair_rsp%0d", i), 64'(rsp_vld), 64'(prev));
      if (i > 0)
        chk($sformatf("fair_data%0d", i), 64'(rsp_rdata),
            (prev == 2'b01) ? 64'hDEADBEEF : 64'h5A5A5A5A);
      prev = fair_exp[i];
      cyc();
    end
    req_vld = 2'b00; settle();
    chk("fair_rsp_last", 64'(rsp_vld), 64'(2'b10));
    chk("fair_data_last", 64'(rsp_rdata), 64'h5A5A5A5A);
    cyc();

    // Reset with a read pending: nothing accepted, no response.
    rst = 1'b1; req_vld = 2'b01; settle();
    chk("rstrd_rdy", 64'(req_rdy), 64'(2'b00));
    cyc(); settle();
    chk("rstrd_rsp", 64'(rsp_vld), 64'(2'b00));

    // Lock: req0 holds lock, both valid; pointer back on requester 1.
    rst = 1'b0; req_vld = 2'b11; req_lock = 2'b01;
`ifdef RVL_CTRL_ARB_LOCK_EN
    lock_exp[0] = 2'b01; lock_exp[1] = 2'b01; lock_exp[2] = 2'b01;
    lock_exp[3] = 2'b01; lock_exp[4] = 2'b10;
`else
    lock_exp[0] = 2'b01; lock_exp[1] = 2'b10; lock_exp[2] = 2'b01;
    lock_exp[3] = 2'b10; lock_exp[4] = 2'b01;
`endif
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("lock_rdy%0d", i), 64'(req_rdy), 64'(lock_exp[i]));
      cyc();
    end

    // Lock drop: after the last step above, the pointer sits on requester 1
    // with the lock build and on requester 0 without. Step to req0 granted.
`ifndef RVL_CTRL_ARB_LOCK_EN
    settle();
    chk("drop_pre", 64'(req_rdy), 64'(2'b10));
    cyc();
`endif
    settle();
    chk("drop_own", 64'(req_rdy), 64'(2'b01));
    cyc();
    req_vld = 2'b10; settle();
    chk("drop_other", 64'(req_rdy), 64'(2'b10));
    cyc();
    req_vld = 2'b11; settle();
    chk("relock0", 64'(req_rdy), 64'(2'b01));
    cyc(); settle();
`ifdef RVL_CTRL_ARB_LOCK_EN
    chk("relock1", 64'(req_rdy), 64'(2'b01));
`else
    chk("relock1", 64'(req_rdy), 64'(2'b10));
`endif
    cyc();
    req_vld = 2'b00; req_lock = 2'b00;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
